stoch2bin3: RTL and testbench

STOCH2BIN3 -- requirements
Module: stoch2bin3

---
 rtl/dsc_pkg.sv | 19 +
 rtl/counter.sv | 34 +++
 rtl/stoch2bin3.sv | 155 +++++++++++++++
 tb/tb_stoch2bin3.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// -----------------------------------------------------------------------------
// dsc_pkg
// Shared definitions for the stochastic-to-binary decoder family.
//   DEF_BITS   : default binary word width (frame length is 2**DEF_BITS cycles)
//   NUM_LANES  : number of stochastic lanes decoded in parallel
//   state_t    : decoder FSM encoding (also exported on the debug state port)
// -----------------------------------------------------------------------------
package dsc_pkg;

    localparam int DEF_BITS  = 4;
    localparam int NUM_LANES = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : dsc_pkg

// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
// Up-counter with synchronous reset, synchronous clear and count enable.
// Reset and clear both win over enable.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   i_clr  : synchronous clear to zero
//   i_en   : increment by one when high
//   o_q    : current count (WIDTH bits)
// -----------------------------------------------------------------------------
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule : counter

// File: rtl/stoch2bin3.sv
// -----------------------------------------------------------------------------
// stoch2bin3
// Decodes three stochastic bitstreams into binary words by counting ones over
// a frame of 2**BITS consecutive samples.
//
// Handshake: start is a request sampled only in IDLE or DONE; the frame is
// sampled while busy=1 (one sample per cycle, exactly 2**BITS cycles), and
// done pulses for one cycle with bin_*/sat (and order_err) valid. Results are
// held until the next done pulse. start during a frame is ignored.
//
// Ports:
//   clk, rst          : clock; synchronous active-high reset
//   start             : request to decode one frame
//   sn_a, sn_b, sn_c  : stochastic bitstreams
//   busy              : high while the frame is being sampled (ACCUM)
//   done              : one-cycle result-valid pulse (DONE)
//   bin_a/b/c         : decoded counts, saturated to 2**BITS-1
//   sat               : per-lane saturation flag (bit0=a, bit1=b, bit2=c)
//   order_err         : only with STOCH2BIN3_ORDER_CHK_EN defined; set when
//                       bin_a >= bin_b >= bin_c does not hold
//   dbg_state         : current FSM state (dsc_pkg::state_t encoding)
//
// Build option: define STOCH2BIN3_ORDER_CHK_EN to add the ordering check.
// -----------------------------------------------------------------------------
module stoch2bin3
    import dsc_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sn_a,
    input  logic                 sn_b,
    input  logic                 sn_c,
    output logic                 busy,
    output logic                 done,
    output logic [BITS-1:0]      bin_a,
    output logic [BITS-1:0]      bin_b,
    output logic [BITS-1:0]      bin_c,
    output logic [NUM_LANES-1:0] sat,
`ifdef STOCH2BIN3_ORDER_CHK_EN
    output logic                 order_err,
`endif
    output logic [1:0]           dbg_state
);

    localparam logic [BITS-1:0] FRAME_LAST = '1;

    state_t          r_state;
    state_t          w_next;
    logic [BITS-1:0] r_frame_cnt;
    logic            w_enter;
    logic            w_last;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ACCUM;
            ACCUM:   if (r_frame_cnt == FRAME_LAST) w_next = DONE;
            DONE:    w_next = start ? ACCUM : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Entering ACCUM (from IDLE or DONE) clears the frame counter and the
    // accumulators so the first sample lands in the first ACCUM cycle.
    assign w_enter = (w_next == ACCUM) && (r_state != ACCUM);
    assign w_last  = (r_state == ACCUM) && (r_frame_cnt == FRAME_LAST);

    // Frame counter wraps from 2**BITS-1 back to 0 on the last sample.
    always_ff @(posedge clk) begin
        if (rst || w_enter) begin
            r_frame_cnt <= '0;
        end else if (r_state == ACCUM) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign busy      = (r_state == ACCUM);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

    // ---------------------------------------------------------------- lanes
    logic [NUM_LANES-1:0] w_sn;
    logic [BITS:0]        w_acc   [NUM_LANES];
    logic [BITS:0]        w_total [NUM_LANES];
    logic [BITS-1:0]      w_bin_nx[NUM_LANES];
    logic [NUM_LANES-1:0] w_sat_nx;

    assign w_sn = {sn_c, sn_b, sn_a};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        counter #(
            .WIDTH(BITS + 1)
        ) u_acc (
            .i_clk (clk),
            .i_rst (rst),
            .i_clr (w_enter),
            .i_en  (w_sn[l] & busy),
            .o_q   (w_acc[l])
        );

        // The accumulator has not yet absorbed the sample of the last ACCUM
        // cycle, so the final count includes the live lane bit.
        assign w_total[l]  = w_acc[l] + {{BITS{1'b0}}, w_sn[l]};
        // A full frame of ones is the only count that reaches the top bit.
        assign w_sat_nx[l] = w_total[l][BITS];
        assign w_bin_nx[l] = w_total[l][BITS] ? {BITS{1'b1}} : w_total[l][BITS-1:0];
    end

    // ---------------------------------------------------------------- results
    logic [BITS-1:0]      r_bin [NUM_LANES];
    logic [NUM_LANES-1:0] r_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) r_bin[i] <= '0;
            r_sat <= '0;
        end else if (w_last) begin
            for (int i = 0; i < NUM_LANES; i++) r_bin[i] <= w_bin_nx[i];
            r_sat <= w_sat_nx;
        end
    end

    assign bin_a = r_bin[0];
    assign bin_b = r_bin[1];
    assign bin_c = r_bin[2];
    assign sat   = r_sat;

`ifdef STOCH2BIN3_ORDER_CHK_EN
    // Compared on the saturated values so it matches what bin_* shows.
    logic r_order_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_order_err <= 1'b0;
        end else if (w_last) begin
            r_order_err <= !((w_bin_nx[0] >= w_bin_nx[1]) && (w_bin_nx[1] >= w_bin_nx[2]));
        end
    end

    assign order_err = r_order_err;
`endif

endmodule : stoch2bin3

// File: tb/tb_stoch2bin3.sv
// -----------------------------------------------------------------------------
// tb_stoch2bin3
// Self-checking bench for stoch2bin3 (BITS=4). Expected results are pushed to
// exp_q when a frame is driven and popped by the monitor on each done pulse.
// Define STOCH2BIN3_ORDER_CHK_EN for both DUT and bench to cover order_err.
// -----------------------------------------------------------------------------
module tb_stoch2bin3;

    localparam int BITS = 4;
    localparam int W    = 3 * BITS + 4;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            sn_a = 1'b0;
    logic            sn_b = 1'b0;
    logic            sn_c = 1'b0;
    logic            busy;
    logic            done;
    logic [BITS-1:0] bin_a;
    logic [BITS-1:0] bin_b;
    logic [BITS-1:0] bin_c;
    logic [2:0]      sat;
    logic [1:0]      dbg_state;
    logic            w_oe;

`ifdef STOCH2BIN3_ORDER_CHK_EN
    logic order_err;
    assign w_oe = order_err;
`else
    assign w_oe = 1'b0;
`endif

    stoch2bin3 #(.BITS(BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sn_a      (sn_a),
        .sn_b      (sn_b),
        .sn_c      (sn_c),
        .busy      (busy),
        .done      (done),
        .bin_a     (bin_a),
        .bin_b     (bin_b),
        .bin_c     (bin_c),
        .sat       (sat),
`ifdef STOCH2BIN3_ORDER_CHK_EN
        .order_err (order_err),
`endif
        .dbg_state (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    // ---------------------------------------------------------------- model
    function automatic logic [W-1:0] expect_of(input logic [15:0] a,
                                               input logic [15:0] b,
                                               input logic [15:0] c);
        int              cnt[3];
        logic [BITS-1:0] bn[3];
        logic [2:0]      s;
        logic            oe;
        cnt[0] = $countones(a);
        cnt[1] = $countones(b);
        cnt[2] = $countones(c);
        s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (cnt[i] == 16) begin
                bn[i] = 4'd15;
                s[i]  = 1'b1;
            end else begin
                bn[i] = cnt[i][BITS-1:0];
            end
        end
`ifdef STOCH2BIN3_ORDER_CHK_EN
        oe = !((bn[0] >= bn[1]) && (bn[1] >= bn[2]));
`else
        oe = 1'b0;
`endif
        return {oe, s, bn[2], bn[1], bn[0]};
    endfunction

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (!rst && done) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done t=%0t got {oe,sat,c,b,a}=%h required no done", $time,
                         {w_oe, sat, bin_c, bin_b, bin_a});
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({w_oe, sat, bin_c, bin_b, bin_a} !== e) begin
                    n_err++;
                    $display("FAIL result t=%0t got {oe,sat,c,b,a}=%h required %h", $time,
                             {w_oe, sat, bin_c, bin_b, bin_a}, e);
                end
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) sync();
        rst = 1'b0;
    endtask

    // One frame from IDLE: start in cycle T, samples T+1..T+16, done at T+17,
    // IDLE at T+18. If ign_k is non-zero, start is pulsed again at T+ign_k.
    task automatic run_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input int ign_k, input string name);
        exp_q.push_back(expect_of(a, b, c));
        start = 1'b1;
        sync();
        for (int i = 0; i < 16; i++) begin
            start = (i + 1 == ign_k);
            sn_a = a[i];
            sn_b = b[i];
            sn_c = c[i];
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s_accum k=%0d got busy=%b done=%b required busy=1 done=0",
                         name, i + 1, busy, done);
            end
            sync();
        end
        start = 1'b0;
        sn_a = 1'($urandom_range(0, 1));
        sn_b = 1'($urandom_range(0, 1));
        sn_c = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd2) begin
            n_err++;
            $display("FAIL %s_done_T17 got done=%b busy=%b state=%0d required 1 0 2",
                     name, done, busy, dbg_state);
        end
        sync();
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL %s_idle_T18 got done=%b busy=%b state=%0d required 0 0 0",
                     name, done, busy, dbg_state);
        end
        sync();
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec++;
        if ({busy, done, bin_a, bin_b, bin_c, sat, w_oe, dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_state got busy=%b done=%b a=%0d b=%0d c=%0d sat=%b oe=%b st=%0d required all 0",
                     busy, done, bin_a, bin_b, bin_c, sat, w_oe, dbg_state);
        end
        sync();
    endtask

    task automatic test_basic();
        run_frame(16'h03FF, 16'h0A5A, 16'h0000, 0, "basic");
    endtask

    task automatic test_saturate();
        run_frame(16'hFFFF, 16'h00F0, 16'h0001, 0, "saturate");
    endtask

    task automatic test_order();
        run_frame(16'h0007, 16'h01FF, 16'h0300, 0, "order");
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), 0, "random");
        end
    endtask

    task automatic test_start_ignored();
        run_frame(16'h5555, 16'h1111, 16'h0101, 5, "ignored");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || dbg_state !== 2'd0) begin
                n_err++;
                $display("FAIL ignored_extra_done got done=%b state=%0d required 0 0", done, dbg_state);
            end
            sync();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa[3];
        logic [15:0] pb[3];
        logic [15:0] pc[3];
        int          f;
        int          j;
        logic        exp_done;
        pa[0] = 16'hFFFF; pb[0] = 16'h0F0F; pc[0] = 16'h0003;
        for (int i = 1; i < 3; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
            pc[i] = 16'($urandom);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(expect_of(pa[i], pb[i], pc[i]));
        start = 1'b1;
        sync();
        for (int k = 1; k <= 51; k++) begin
            f = (k - 1) / 17;
            j = (k - 1) % 17;
            if (j < 16) begin
                sn_a = pa[f][j];
                sn_b = pb[f][j];
                sn_c = pc[f][j];
            end else begin
                sn_a = 1'($urandom_range(0, 1));
                sn_b = 1'($urandom_range(0, 1));
                sn_c = 1'($urandom_range(0, 1));
            end
            start = (k != 51);
            exp_done = (j == 16);
            @(negedge clk);
            n_vec++;
            if (done !== exp_done || busy !== !exp_done) begin
                n_err++;
                $display("FAIL b2b_timing k=%0d got done=%b busy=%b required done=%b busy=%b",
                         k, done, busy, exp_done, !exp_done);
            end
            sync();
        end
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end_idle got state=%0d busy=%b required 0 0", dbg_state, busy);
        end
        sync();
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        start = 1'b1;
        sync();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sn_a = 1'b1;
            sn_b = 1'b1;
            sn_c = 1'b1;
            if (i == 7) rst = 1'b1;
            sync();
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, done, bin_a, bin_b, bin_c, sat, w_oe, dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_clear got busy=%b done=%b a=%0d b=%0d c=%0d sat=%b oe=%b st=%0d required all 0",
                     busy, done, bin_a, bin_b, bin_c, sat, w_oe, dbg_state);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sync();
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_no_done got done seen=%b required 0", saw_done);
        end
        sync();
        run_frame(16'h00FF, 16'h000F, 16'h0001, 0, "after_reset");
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_order();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        repeat (2) sync();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_results got %0d outstanding required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stoch2bin3
